i2c_seq_master: RTL and testbench

//  Parametrised I2C write-sequencer; successor to the fixed-table codec init engine.

---
 rtl/i2c_seq_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_i2c_seq_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_seq_master.sv
// i2c_seq_master: holds a codec in power-down after reset, releases it, then streams
// {reg,value} writes from a synchronous ROM to one I2C target with NACK retry and status.
module i2c_seq_master #(
   parameter int unsigned CLK_DIV     = 30,
   parameter logic [6:0]  DEV_ADDR    = 7'h10,
   parameter int unsigned N_REGS      = 16,
   parameter int unsigned PDN_CYCLES  = 4096,
   parameter int unsigned MAX_RETRIES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        scl,
   output logic        sda_out,
   input  logic        sda_in,
   output logic        pdn_out,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_index
);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PDN_W = $clog2(PDN_CYCLES + 1);
   localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PDN_W-1:0] PDN_LAST = PDN_W'(PDN_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
   localparam logic [7:0]       LAST_IDX = 8'(N_REGS - 1);

   typedef enum logic [3:0] {
      S_PDN_LOW, S_PDN_WAIT, S_LOAD, S_START, S_BYTE,
      S_ACK, S_STOP, S_GAP, S_FIN, S_IDLE
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [PDN_W-1:0]   pdn_cnt_q, pdn_cnt_d;
   logic               ld_q, ld_d;
   logic [23:0]        frame_q, frame_d;
   logic [1:0]         step_q, step_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic               nack_q, nack_d;
   logic               scl_q, scl_d;
   logic               sda_q, sda_d;
   logic               pdn_q, pdn_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [7:0]         err_index_q, err_index_d;
   logic [7:0]         rom_addr_q, rom_addr_d;
   logic               tick;

   always_comb begin
      state_d     = state_q;
      pdn_cnt_d   = pdn_cnt_q;
      ld_d        = ld_q;
      frame_d     = frame_q;
      step_d      = step_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      retry_d     = retry_q;
      nack_d      = nack_q;
      scl_d       = scl_q;
      sda_d       = sda_q;
      pdn_d       = pdn_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      rom_addr_d  = rom_addr_q;
      tick        = (div_q == DIV_LAST);
      div_d       = tick ? '0 : div_q + 1'b1;

      case (state_q)
         S_PDN_LOW: begin
            if (pdn_cnt_q == PDN_LAST) begin
               pdn_cnt_d = '0;
               pdn_d     = 1'b1;
               state_d   = S_PDN_WAIT;
            end else begin
               pdn_cnt_d = pdn_cnt_q + 1'b1;
            end
         end
         S_PDN_WAIT: begin
            if (pdn_cnt_q == PDN_LAST) begin
               pdn_cnt_d = '0;
               state_d   = S_LOAD;
            end else begin
               pdn_cnt_d = pdn_cnt_q + 1'b1;
            end
         end
         // First clk lets the ROM register the address; the second captures its data.
         S_LOAD: begin
            if (!ld_q) begin
               ld_d = 1'b1;
            end else begin
               ld_d       = 1'b0;
               frame_d    = {DEV_ADDR, 1'b0, rom_data};
               byte_idx_d = '0;
               bit_idx_d  = '0;
               step_d     = '0;
               nack_d     = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (step_q == 2'd0) begin
                  sda_d  = 1'b0;
                  step_d = 2'd1;
               end else begin
                  scl_d   = 1'b0;
                  step_d  = 2'd0;
                  state_d = S_BYTE;
               end
            end
         end
         S_BYTE: begin
            if (tick) begin
               step_d = step_q + 2'd1;
               case (step_q)
                  2'd0: sda_d = frame_q[23];
                  2'd1: scl_d = 1'b1;
                  2'd3: begin
                     scl_d   = 1'b0;
                     frame_d = {frame_q[22:0], 1'b0};
                     if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_ACK;
                     end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_ACK: begin
            if (tick) begin
               step_d = step_q + 2'd1;
               case (step_q)
                  2'd0: sda_d = 1'b1;
                  2'd1: scl_d = 1'b1;
                  2'd2: if (sda_in) nack_d = 1'b1;
                  default: begin
                     scl_d = 1'b0;
                     if (nack_q) begin
                        state_d = S_STOP;
                     end else if (byte_idx_q == 2'd2) begin
                        retry_d = '0;
                        state_d = S_STOP;
                     end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_BYTE;
                     end
                  end
               endcase
            end
         end
         S_STOP: begin
            if (tick) begin
               step_d = step_q + 2'd1;
               case (step_q)
                  2'd0: sda_d = 1'b0;
                  2'd1: scl_d = 1'b1;
                  default: begin
                     sda_d   = 1'b1;
                     step_d  = '0;
                     state_d = S_GAP;
                  end
               endcase
            end
         end
         S_GAP: begin
            if (tick) begin
               step_d = step_q + 2'd1;
               if (step_q == 2'd3) begin
                  if (nack_q) begin
                     if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_LOAD;
                     end else begin
                        state_d = S_FIN;
                     end
                  end else if (rom_addr_q == LAST_IDX) begin
                     state_d = S_FIN;
                  end else begin
                     rom_addr_d = rom_addr_q + 8'd1;
                     state_d    = S_LOAD;
                  end
               end
            end
         end
         S_FIN: begin
            busy_d = 1'b0;
            scl_d  = 1'b1;
            sda_d  = 1'b1;
            if (nack_q) begin
               error_d     = 1'b1;
               err_index_d = rom_addr_q;
            end else begin
               done_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (start) begin
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_index_d = '0;
               rom_addr_d  = '0;
               retry_d     = '0;
               busy_d      = 1'b1;
               ld_d        = 1'b0;
               state_d     = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_PDN_LOW;
         div_q       <= '0;
         pdn_cnt_q   <= '0;
         ld_q        <= 1'b0;
         frame_q     <= '0;
         step_q      <= '0;
         bit_idx_q   <= '0;
         byte_idx_q  <= '0;
         retry_q     <= '0;
         nack_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         pdn_q       <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         rom_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         pdn_cnt_q   <= pdn_cnt_d;
         ld_q        <= ld_d;
         frame_q     <= frame_d;
         step_q      <= step_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         retry_q     <= retry_d;
         nack_q      <= nack_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         pdn_q       <= pdn_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         rom_addr_q  <= rom_addr_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign scl       = scl_q;
   assign sda_out   = sda_q;
   assign pdn_out   = pdn_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_index = err_index_q;
endmodule

// File: tb/tb_i2c_seq_master.sv
// Bench for i2c_seq_master: ROM and ACK/NACK target model, bus decoder, and a
// frame-level reference model of the write sequence.
module tb_i2c_seq_master;
   localparam int unsigned CLK_DIV     = 4;
   localparam int unsigned N_REGS      = 2;
   localparam int unsigned PDN_CYCLES  = 16;
   localparam int unsigned MAX_RETRIES = 2;
   localparam logic [7:0]  ADDR_BYTE   = 8'h20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic        scl, sda_out, sda_in, pdn_out, busy, done, error;
   logic [7:0]  err_index;
   logic        ack_drive = 1'b0;

   logic [15:0] rom [256];
   int unsigned nack_byte [$];
   logic [31:0] mon_q [$];
   logic [31:0] exp_frames [$];
   logic        exp_done, exp_err;
   logic [7:0]  exp_idx;
   int          checks = 0;
   int          errors = 0;

   int unsigned start_count = 0, cur_att = 0, bitcnt = 0, nbytes = 0, viol = 0;
   bit          in_frame = 0, seen_rise = 0;
   logic [7:0]  cur_byte = '0;
   logic [23:0] bytes_acc = '0;
   logic        ps = 1'b1, pd = 1'b1;

   i2c_seq_master #(
      .CLK_DIV(CLK_DIV), .DEV_ADDR(7'h10), .N_REGS(N_REGS),
      .PDN_CYCLES(PDN_CYCLES), .MAX_RETRIES(MAX_RETRIES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .scl(scl), .sda_out(sda_out), .sda_in(sda_in), .pdn_out(pdn_out), .busy(busy),
      .done(done), .error(error), .err_index(err_index)
   );

   assign sda_in = sda_out & ~ack_drive;
   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   function automatic int unsigned plan_nack(int unsigned att);
      if (att < nack_byte.size()) return nack_byte[att];
      return 3;
   endfunction

   // Open-drain bus decoder plus target: ACKs unless the plan NACKs this byte of this attempt.
   always @(negedge clk) begin
      logic s, d;
      s = scl;
      d = sda_in;
      if (rst) begin
         in_frame = 0; seen_rise = 0; bitcnt = 0; ack_drive = 1'b0;
      end else begin
         if (rom_addr > 8'(N_REGS - 1)) viol++;
         if (s != ps && d != pd) viol++;
         else if (s && ps && d != pd) begin
            if (!d) begin
               if (in_frame) viol++;
               in_frame = 1; seen_rise = 0; bitcnt = 0; nbytes = 0; bytes_acc = '0;
               cur_att = start_count;
               start_count++;
            end else begin
               if (!in_frame || bitcnt != 0) viol++;
               else mon_q.push_back({8'(nbytes), bytes_acc});
               in_frame = 0;
            end
         end else if (in_frame && s && !ps) begin
            seen_rise = 1;
            if (bitcnt < 8) cur_byte = {cur_byte[6:0], d};
         end else if (in_frame && !s && ps && seen_rise) begin
            seen_rise = 0;
            bitcnt++;
            if (bitcnt == 8) begin
               if (nbytes < 3) bytes_acc = bytes_acc | (24'(cur_byte) << (16 - 8 * nbytes));
               ack_drive = (plan_nack(cur_att) != nbytes);
               nbytes++;
            end else if (bitcnt == 9) begin
               bitcnt = 0;
               ack_drive = 1'b0;
            end
         end
      end
      ps = s;
      pd = d;
   end

   function automatic logic [23:0] frame_bytes(int unsigned e, int unsigned nb);
      logic [23:0] full;
      full = {ADDR_BYTE, rom[8'(e)]};
      if (nb == 1) return full & 24'hFF0000;
      if (nb == 2) return full & 24'hFFFF00;
      return full;
   endfunction

   // Expected frames: each entry retried until ACKed or until MAX_RETRIES re-attempts fail.
   task automatic build_model();
      int unsigned att, tries, k;
      bit ok;
      att = 0;
      exp_frames.delete();
      exp_err = 1'b0;
      exp_idx = '0;
      for (int unsigned e = 0; e < N_REGS && !exp_err; e++) begin
         tries = 0;
         ok = 0;
         while (!ok && !exp_err) begin
            k = plan_nack(att);
            att++;
            if (k >= 3) begin
               exp_frames.push_back({8'd3, frame_bytes(e, 3)});
               ok = 1;
            end else begin
               exp_frames.push_back({8'(k + 1), frame_bytes(e, k + 1)});
               tries++;
               if (tries > MAX_RETRIES) begin
                  exp_err = 1'b1;
                  exp_idx = 8'(e);
               end
            end
         end
      end
      exp_done = !exp_err;
   endtask

   function automatic int first_bad_frame();
      if (mon_q.size() != exp_frames.size()) return 1000;
      foreach (mon_q[i]) if (mon_q[i] !== exp_frames[i]) return i;
      return -1;
   endfunction

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pdn_rise(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (pdn_out) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic pulse_start();
      mon_q.delete();
      start_count = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic random_rom();
      for (int unsigned e = 0; e < N_REGS; e++) rom[8'(e)] = 16'($urandom);
   endtask

   task automatic check_frames_status(string name);
      int bad;
      bad = first_bad_frame();
      checks++;
      if (bad != -1) begin
         errors++;
         if (bad >= 0 && bad < mon_q.size())
            $display("FAIL %s frames: frame %0d got %h expected %h", name, bad, mon_q[bad], exp_frames[bad]);
         else
            $display("FAIL %s frames: got %0d frames expected %0d", name, mon_q.size(), exp_frames.size());
      end
      checks++;
      if ({busy, done, error, err_index, pdn_out} !== {1'b0, exp_done, exp_err, exp_idx, 1'b1}) begin
         errors++;
         $display("FAIL %s status: got busy=%b done=%b error=%b idx=%0d pdn=%b expected 0 %b %b %0d 1",
                  name, busy, done, error, err_index, pdn_out, exp_done, exp_err, exp_idx);
      end
   endtask

   task automatic test_reset();
      int n;
      rom[0] = 16'h0112;
      rom[1] = 16'h02AB;
      nack_byte.delete();
      repeat (2) @(negedge clk);
      checks++;
      if ({scl, sda_out, pdn_out, busy, done, error, rom_addr, err_index} !== {6'b110100, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values: got scl=%b sda=%b pdn=%b busy=%b done=%b err=%b addr=%0d idx=%0d expected 1 1 0 1 0 0 0 0",
                  scl, sda_out, pdn_out, busy, done, error, rom_addr, err_index);
      end
      rst = 1'b0;
      pdn_rise(n);
      checks++;
      if (n != PDN_CYCLES) begin
         errors++;
         $display("FAIL pdn_release: got clk %0d expected %0d", n, PDN_CYCLES);
      end
   endtask

   task automatic test_boot();
      bit ok;
      build_model();
      wait_idle(5000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL boot_timeout: got busy=%b expected 0", busy);
      end
      checks++;
      if (mon_q.size() != 2 || mon_q[0] !== 32'h03200112 || mon_q[1] !== 32'h032002AB) begin
         errors++;
         $display("FAIL boot_bytes: got %0d frames expected 03200112 032002AB", mon_q.size());
      end
      check_frames_status("boot");
   endtask

   task automatic test_nack_retry();
      bit ok;
      random_rom();
      nack_byte.delete();
      nack_byte.push_back(3);
      nack_byte.push_back($urandom_range(2, 0));
      build_model();
      pulse_start();
      checks++;
      if ({rom_addr, done, busy, pdn_out} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL rerun_start: got addr=%0d done=%b busy=%b pdn=%b expected 0 0 1 1", rom_addr, done, busy, pdn_out);
      end
      wait_idle(8000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL retry_timeout: got busy=%b expected 0", busy);
      end
      check_frames_status("nack_retry");
   endtask

   task automatic test_error();
      bit ok;
      random_rom();
      nack_byte.delete();
      for (int i = 0; i < 3; i++) nack_byte.push_back($urandom_range(2, 0));
      build_model();
      pulse_start();
      wait_idle(8000, ok);
      checks++;
      if (!ok || mon_q.size() != MAX_RETRIES + 1) begin
         errors++;
         $display("FAIL error_frames: got %0d frames expected %0d", mon_q.size(), MAX_RETRIES + 1);
      end
      check_frames_status("error");
   endtask

   task automatic test_random();
      bit ok;
      for (int r = 0; r < 4; r++) begin
         random_rom();
         nack_byte.delete();
         for (int i = 0; i < 8; i++)
            nack_byte.push_back(($urandom_range(9, 0) < 3) ? $urandom_range(2, 0) : 3);
         build_model();
         pulse_start();
         checks++;
         if ({error, err_index, done} !== 10'd0) begin
            errors++;
            $display("FAIL random_clear: got error=%b idx=%0d done=%b expected 0 0 0", error, err_index, done);
         end
         wait_idle(10000, ok);
         check_frames_status("random");
      end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      int n;
      random_rom();
      nack_byte.delete();
      build_model();
      pulse_start();
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_idle(8000, ok);
      check_frames_status("busy_start");
      n = mon_q.size();
      repeat (600) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mon_q.size() != n || n != N_REGS) begin
         errors++;
         $display("FAIL busy_start_dropped: got busy=%b frames=%0d expected 0 %0d", busy, mon_q.size(), N_REGS);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, hit;
      int n;
      nack_byte.delete();
      build_model();
      pulse_start();
      hit = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rom_addr == 8'd1 && in_frame && bitcnt == 3) begin
            hit = 1;
            break;
         end
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (!hit || {scl, sda_out, pdn_out, busy, done} !== 5'b11010) begin
         errors++;
         $display("FAIL reset_mid: got hit=%b scl=%b sda=%b pdn=%b busy=%b done=%b expected 1 1 1 0 1 0",
                  hit, scl, sda_out, pdn_out, busy, done);
      end
      repeat (3) @(negedge clk);
      mon_q.delete();
      start_count = 0;
      rst = 1'b0;
      pdn_rise(n);
      checks++;
      if (n != PDN_CYCLES) begin
         errors++;
         $display("FAIL reset_mid_pdn: got clk %0d expected %0d", n, PDN_CYCLES);
      end
      wait_idle(5000, ok);
      check_frames_status("reset_mid");
   endtask

   initial begin
      test_reset();
      test_boot();
      test_nack_retry();
      test_error();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL bus_protocol: got %0d violations expected 0", viol);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
